// File: rtl/amo_reservation_tracker.sv
// LR/SC reservation responder: holds one reservation block, answers SCs and
// stalls matching snoops for LR_WAIT cycles after each LR.
module amo_reservation_tracker #(
  parameter int unsigned LR_WAIT           = 32,
  parameter int unsigned RESERVATION_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lr_valid,
  input  logic [31:0] lr_addr,
  input  logic        sc_valid,
  input  logic [31:0] sc_addr,
  output logic        sc_done,
  output logic        sc_success,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        snoop_ready,
  input  logic        clear,
  output logic        reservation_valid,
  output logic        protected_window
);

  localparam int unsigned BLK_LSB = 2 + $clog2(RESERVATION_WORDS);
  localparam int unsigned BLK_W   = 32 - BLK_LSB;
  // A zero-length window still needs a legal one-bit counter.
  localparam int unsigned CNT_W   = (LR_WAIT == 0) ? 1 : $clog2(LR_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LR_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PROTECTED = 2'd1,
    ST_RESERVED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               sc_done_q, sc_done_d;
  logic               sc_success_q, sc_success_d;

  logic snoop_match, sc_match, snoop_kill;

  assign snoop_match = (snoop_addr[31:BLK_LSB] == blk_q);
  assign sc_match    = (sc_addr[31:BLK_LSB] == blk_q);

  // Only the low address bits inside a block are ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{lr_addr[BLK_LSB-1:0], sc_addr[BLK_LSB-1:0],
                             snoop_addr[BLK_LSB-1:0]};

  assign snoop_ready       = !((state_q == ST_PROTECTED) && snoop_valid && snoop_match);
  assign reservation_valid = (state_q != ST_IDLE);
  assign protected_window  = (state_q == ST_PROTECTED);
  assign sc_done           = sc_done_q;
  assign sc_success        = sc_success_q;

  // Next-state: clear > LR > (accepted snoop kill | SC) > window countdown.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    snoop_kill   = (state_q == ST_RESERVED) && snoop_valid && snoop_match;
    sc_done_d    = sc_valid;
    sc_success_d = sc_valid && !clear && !snoop_kill &&
                   (state_q != ST_IDLE) && sc_match;

    if (state_q == ST_PROTECTED) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = ST_RESERVED;
    end

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (lr_valid) begin
      blk_d = lr_addr[31:BLK_LSB];
      if (LR_WAIT > 0) begin
        state_d = ST_PROTECTED;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = ST_RESERVED;
        cnt_d   = '0;
      end
    end else if (snoop_kill || sc_valid) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      blk_q        <= '0;
      sc_done_q    <= 1'b0;
      sc_success_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      sc_done_q    <= sc_done_d;
      sc_success_q <= sc_success_d;
    end
  end

endmodule
